// File: rtl/feistel_round_engine.sv
// DES Feistel round engine: 16 rounds with an on-the-fly key schedule, UNROLL rounds per clock.
// Operates on the IP-permuted halves and the PC-1 key; IP^-1 is left to the consumer.
module feistel_round_engine #(
    parameter int unsigned UNROLL     = 1,
    parameter int unsigned SWAP_FINAL = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic        DECRYPT,
    input  logic [32:1] LEFT_IN,
    input  logic [32:1] RIGHT_IN,
    input  logic [56:1] CD_IN,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [32:1] LEFT_OUT,
    output logic [32:1] RIGHT_OUT,
    output logic        BUSY
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16))
    begin : g_bad_unroll
        $fatal(1, "feistel_round_engine: UNROLL must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [3:0] CNT_STEP = 4'(UNROLL);
    localparam logic [3:0] LAST_CNT = 4'(16 - UNROLL);

    // Tables use FIPS 46-3 numbering: entry values are 1-based, MSB-first bit positions.
    localparam int unsigned E_TAB [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };
    localparam int unsigned P_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };
    localparam int unsigned PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
        26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int unsigned SHIFT_TAB [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    // S1..S8, each 4 rows x 16 columns, row-major.
    localparam int unsigned SBOX [512] = '{
        14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
         0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
         4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
        15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13,
        15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
         3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
         0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
        13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9,
        10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
        13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
        13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
         1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12,
         7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
        13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
        10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
         3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14,
         2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
        14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
         4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
        11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3,
        12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
        10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
         9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
         4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13,
         4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
        13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
         1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
         6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12,
        13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
         1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
         7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
         2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11
    };

    function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] p;
        logic [5:0]  b;
        int unsigned idx;
        for (int unsigned i = 0; i < 48; i++) x[47 - i] = r[32 - E_TAB[i]];
        x = x ^ k;
        for (int unsigned n = 0; n < 8; n++) begin
            b = x[47 - 6 * n -: 6];
            idx = 64 * n + 16 * 32'({b[5], b[0]}) + 32'(b[4:1]);
            s[31 - 4 * n -: 4] = 4'(SBOX[idx]);
        end
        for (int unsigned i = 0; i < 32; i++) p[31 - i] = s[32 - P_TAB[i]];
        return p;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] k;
        for (int unsigned i = 0; i < 48; i++) k[47 - i] = cd[56 - PC2_TAB[i]];
        return k;
    endfunction

    function automatic logic [55:0] rot_cd(input logic [55:0] cd, input logic left,
                                           input int unsigned amt);
        logic [27:0] c;
        logic [27:0] d;
        c = cd[55:28];
        d = cd[27:0];
        for (int unsigned i = 0; i < 2; i++) begin
            if (i < amt) begin
                if (left) begin
                    c = {c[26:0], c[27]};
                    d = {d[26:0], d[27]};
                end else begin
                    c = {c[0], c[27:1]};
                    d = {d[0], d[27:1]};
                end
            end
        end
        return {c, d};
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [55:0] cd_q, cd_d;
    logic        dec_q, dec_d;
    logic [31:0] out_l_q, out_l_d, out_r_q, out_r_d;

    logic [31:0] l_t, r_t, tmp_t;
    logic [55:0] cd_t;
    logic [47:0] k_t;
    int unsigned rnd;
    logic        in_ready, accept;

    // Round chain. Decrypt uses the current CD then rotates right, so the net rotation is 28.
    always_comb begin
        l_t   = l_q;
        r_t   = r_q;
        cd_t  = cd_q;
        k_t   = '0;
        tmp_t = '0;
        rnd   = 0;
        for (int unsigned j = 0; j < UNROLL; j++) begin
            rnd = 32'(cnt_q) + j;
            if (!dec_q) begin
                cd_t = rot_cd(cd_t, 1'b1, SHIFT_TAB[rnd]);
                k_t  = pc2(cd_t);
            end else begin
                k_t  = pc2(cd_t);
                cd_t = rot_cd(cd_t, 1'b0, SHIFT_TAB[15 - rnd]);
            end
            tmp_t = r_t;
            r_t   = l_t ^ f_func(r_t, k_t);
            l_t   = tmp_t;
        end
    end

    always_comb begin
        in_ready = !RST && (state_q == StIdle || (state_q == StDone && OUT_READY));
        accept   = IN_VALID && in_ready;
        state_d  = state_q;
        cnt_d    = cnt_q;
        l_d      = l_q;
        r_d      = r_q;
        cd_d     = cd_q;
        dec_d    = dec_q;
        out_l_d  = out_l_q;
        out_r_d  = out_r_q;
        unique case (state_q)
            StIdle: ;
            StRun: begin
                l_d   = l_t;
                r_d   = r_t;
                cd_d  = cd_t;
                cnt_d = cnt_q + CNT_STEP;
                if (cnt_q == LAST_CNT) begin
                    state_d = StDone;
                    out_l_d = (SWAP_FINAL != 0) ? r_t : l_t;
                    out_r_d = (SWAP_FINAL != 0) ? l_t : r_t;
                end
            end
            StDone: begin
                if (OUT_READY) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (accept) begin
            state_d = StRun;
            cnt_d   = '0;
            l_d     = LEFT_IN;
            r_d     = RIGHT_IN;
            cd_d    = CD_IN;
            dec_d   = DECRYPT;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            l_q     <= '0;
            r_q     <= '0;
            cd_q    <= '0;
            dec_q   <= 1'b0;
            out_l_q <= '0;
            out_r_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            l_q     <= l_d;
            r_q     <= r_d;
            cd_q    <= cd_d;
            dec_q   <= dec_d;
            out_l_q <= out_l_d;
            out_r_q <= out_r_d;
        end
    end

    assign IN_READY  = in_ready;
    assign OUT_VALID = (state_q == StDone);
    assign BUSY      = (state_q == StRun);
    assign LEFT_OUT  = out_l_q;
    assign RIGHT_OUT = out_r_q;

endmodule

// File: doc/feistel_round_engine.md
FEISTEL_ROUND_ENGINE -- requirements
Module: feistel_round_engine

Interface
REQ-001 The block SHALL have parameter UNROLL, default 1: DES rounds evaluated per clock; legal values 1, 2, 4, 8, 16; any other value SHALL fail elaboration.
REQ-002 The block SHALL have parameter SWAP_FINAL, default 1: 1 = output the preoutput block R16||L16 (DES final swap applied); 0 = output L16||R16.
REQ-003 The block SHALL have port CLK, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port IN_VALID, input, 1 bit: the input block and key are valid.
REQ-006 The block SHALL have port IN_READY, output, 1 bit: the engine can accept an input this cycle.
REQ-007 The block SHALL have port DECRYPT, input, 1 bit: mode, sampled on accept; 1 = decrypt key order.
REQ-008 The block SHALL have port LEFT_IN, input, [32:1]: L0, i.e. the left half after IP.
REQ-009 The block SHALL have port RIGHT_IN, input, [32:1]: R0, i.e. the right half after IP.
REQ-010 The block SHALL have port CD_IN, input, [56:1]: C0||D0, i.e. the key after PC-1.
REQ-011 The block SHALL have port OUT_VALID, output, 1 bit: LEFT_OUT/RIGHT_OUT hold a finished result.
REQ-012 The block SHALL have port OUT_READY, input, 1 bit: the consumer accepts the result.
REQ-013 The block SHALL have port LEFT_OUT, output, [32:1]: left result half, before IP^-1.
REQ-014 The block SHALL have port RIGHT_OUT, output, [32:1]: right result half, before IP^-1.
REQ-015 The block SHALL have port BUSY, output, 1 bit: high while in RUN.

Function
REQ-016 The FSM SHALL have the states IDLE, RUN and DONE; a round counter SHALL count 0..15 in steps of UNROLL.
REQ-017 IN_READY SHALL be high in IDLE, and high in DONE when OUT_READY=1; it SHALL be low in RUN and while RST=1.
REQ-018 On accept (IN_VALID & IN_READY): the block SHALL register L, R, CD and mode, clear the counter and go to RUN.
REQ-019 Each RUN cycle SHALL apply UNROLL chained Feistel rounds.
REQ-020 The Feistel rounds SHALL be: L' = R; R' = L xor P(S(E(R) xor K)), with standard FIPS 46-3 E, S1-S8 and P.
REQ-021 Each RUN cycle SHALL advance the counter by UNROLL.
REQ-022 Encrypt subkey for round i (1..16): CD SHALL be rotated left, each half independently, by shift[i] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1; K_i = PC-2 of the result.
REQ-023 Decrypt subkey for round i: the rotation before round i SHALL be right by 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1; K_i = PC-2 of the result, so round 1 uses K16.
REQ-024 Latency SHALL be 16/UNROLL RUN cycles; OUT_VALID SHALL rise on the cycle after the last RUN cycle.
REQ-025 The FSM SHALL then enter DONE, with the outputs loaded per SWAP_FINAL.
REQ-026 In DONE, outputs SHALL be held stable until OUT_READY=1; OUT_VALID=1 with OUT_READY=0 SHALL hold everything.
REQ-027 DONE with OUT_READY=1 and IN_VALID=0 SHALL go to IDLE with OUT_VALID=0 next cycle.
REQ-028 DONE with OUT_READY=1 and IN_VALID=1 SHALL consume the result and accept the new block in the same cycle; the FSM SHALL go to RUN, with no idle bubble.
REQ-029 IN_VALID during RUN SHALL be ignored, and no input sampled; DECRYPT and CD_IN changes after accept SHALL have no effect.
REQ-030 The CD register SHALL have completed a net rotation of 28 per half at the end of the operation, for either mode.
REQ-031 The f-function path SHALL be purely combinational between registers; no combinational path SHALL exist from IN_VALID to OUT_VALID.

Reset
REQ-032 While RST=1 at a CLK edge: FSM SHALL be IDLE, counter 0, OUT_VALID=0, BUSY=0, and LEFT_OUT/RIGHT_OUT/internal L, R, CD = 0.
REQ-033 RST SHALL abort an operation in RUN or DONE; the pending result SHALL be discarded and never presented.
REQ-034 IN_READY SHALL be 1 on the first cycle after RST deasserts.

Verification
REQ-035 Encrypt, UNROLL=1, SWAP_FINAL=1: LEFT_IN=CC00CCFF, RIGHT_IN=F0AAF0AA, CD_IN=F0CCAAF_556678F -> after 16 RUN cycles OUT_VALID=1, LEFT_OUT=0A4CD995, RIGHT_OUT=43423234.
REQ-036 Decrypt, UNROLL=1: LEFT_IN=0A4CD995, RIGHT_IN=43423234, same CD_IN -> LEFT_OUT=CC00CCFF, RIGHT_OUT=F0AAF0AA.
REQ-037 Repeat REQ-035 for UNROLL=2, 4, 8 and 16 -> identical result after 8, 4, 2 and 1 RUN cycles respectively.
REQ-038 UNROLL=16 single-round visibility via UNROLL=1 probe: after the first RUN cycle, internal L=F0AAF0AA, R=EF4A6544.
REQ-039 Backpressure: hold OUT_READY=0 for 5 cycles in DONE -> outputs stable and IN_READY=0; then OUT_READY=1 with IN_VALID=1 -> new block accepted that cycle and BUSY=1 next.
REQ-040 Reset mid-RUN (counter=8) -> next cycle IDLE, OUT_VALID=0, all outputs 0, and no result emitted afterwards.
